// File: rtl/cpu_pkg.sv
// Shared CPU definitions: bus driver indices and the bus arbiter state encoding.
package cpu_pkg;

  localparam int BUS_NUM_REQ = 7;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_OWNED = 2'd1,
    ARB_GAP   = 2'd2
  } arb_state_e;

  // Index 0 is the control unit and always has priority on the bus.
  typedef enum logic [2:0] {
    BUS_REQ_CU  = 3'd0,
    BUS_REQ_RAX = 3'd1,
    BUS_REQ_RBX = 3'd2,
    BUS_REQ_RCX = 3'd3,
    BUS_REQ_RDX = 3'd4,
    BUS_REQ_ALU = 3'd5,
    BUS_REQ_MEM = 3'd6
  } bus_req_e;

endpackage

// File: rtl/bus_rr_picker.sv
// Combinational round-robin pick over requesters 1..NUM_REQ-1, searching from
// i_ptr+1 and wrapping NUM_REQ-1 back to 1. Index 0 is handled by the caller.
module bus_rr_picker #(
  parameter int NUM_REQ = 7
) (
  input  logic [NUM_REQ-1:1]         i_req,
  input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
  output logic [NUM_REQ-1:1]         o_pick,
  output logic [$clog2(NUM_REQ)-1:0] o_idx,
  output logic                       o_valid
);

  localparam int IDX_W = $clog2(NUM_REQ);

  always_comb begin : pick_loop
    int w_cand;
    o_pick  = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_cand  = 0;
    for (int k = 1; k < NUM_REQ; k++) begin
      w_cand = int'(i_ptr) + k;
      if (w_cand > NUM_REQ - 1) w_cand = w_cand - (NUM_REQ - 1);
      if (!o_valid && i_req[w_cand]) begin
        o_valid        = 1'b1;
        o_idx          = IDX_W'(w_cand);
        o_pick[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Shared 8-bit CPU bus arbiter: one-hot registered grant, priority for the
// control unit, round-robin for the rest, optional turnaround gap, watchdog.
module bus_arbiter
  import cpu_pkg::*;
#(
  parameter int NUM_REQ    = BUS_NUM_REQ,
  parameter int MAX_HOLD   = 15,
  parameter int TURNAROUND = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         lock,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       bus_busy,
  output logic                       timeout,
  output logic [1:0]                 o_dbg_state
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  // Handshake: req[i] is a level held for as long as driver i wants to drive;
  // driver i may drive the bus only in cycles where grant[i]=1. A grant
  // always appears one edge after the req that won it, and drops one edge
  // after the cycle in which a release cause is seen.

  arb_state_e              r_state;
  logic [NUM_REQ-1:0]      r_grant;
  logic [IDX_W-1:0]        r_owner;
  logic [IDX_W-1:0]        r_rr_ptr;
  logic [HOLD_W-1:0]       r_hold_cnt;
  logic [NUM_REQ-1:0]      r_mask;

  arb_state_e              w_nxt_state;
  logic [NUM_REQ-1:0]      w_nxt_grant;
  logic [IDX_W-1:0]        w_nxt_owner;
  logic [IDX_W-1:0]        w_nxt_rr_ptr;
  logic [HOLD_W-1:0]       w_nxt_hold_cnt;
  logic [NUM_REQ-1:0]      w_nxt_mask;

  logic                    w_owned;
  logic                    w_own_req;
  logic                    w_own_lock;
  logic                    w_rel_drop;
  logic                    w_rel_preempt;
  logic                    w_rel_wdog;
  logic                    w_release;
  logic [NUM_REQ-1:0]      w_cand;
  logic [NUM_REQ-1:1]      w_pick;
  logic [IDX_W-1:0]        w_pick_idx;
  logic                    w_pick_valid;
  logic                    w_win_valid;
  logic [IDX_W-1:0]        w_win_idx;
  logic [NUM_REQ-1:0]      w_win_grant;

  // Release causes, evaluated only while an owner holds the bus; the
  // priority drop > preempt > watchdog falls out of the qualifiers.
  always_comb begin
    w_owned       = (r_state == ARB_OWNED);
    w_own_req     = req[r_owner];
    w_own_lock    = lock[r_owner];
    w_rel_drop    = w_owned && !w_own_req;
    w_rel_preempt = w_owned && w_own_req && req[0] && (r_owner != '0) && !w_own_lock;
    w_rel_wdog    = w_owned && w_own_req && !w_rel_preempt &&
                    (r_hold_cnt == HOLD_W'(MAX_HOLD));
    w_release     = w_rel_drop || w_rel_preempt || w_rel_wdog;
    w_cand        = req & ~r_mask;
    // A watchdog victim must not win the back-to-back re-arbitration.
    if (w_rel_wdog) w_cand[r_owner] = 1'b0;
  end

  bus_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_picker (
    .i_req   (w_cand[NUM_REQ-1:1]),
    .i_ptr   (r_rr_ptr),
    .o_pick  (w_pick),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  assign w_win_valid = w_cand[0] | w_pick_valid;
  assign w_win_idx   = w_cand[0] ? '0 : w_pick_idx;
  assign w_win_grant = w_cand[0] ? NUM_REQ'(1) : {w_pick, 1'b0};

  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_grant    = r_grant;
    w_nxt_owner    = r_owner;
    w_nxt_rr_ptr   = r_rr_ptr;
    w_nxt_hold_cnt = r_hold_cnt;
    w_nxt_mask     = r_mask & req;
    if (w_rel_wdog) w_nxt_mask[r_owner] = 1'b1;

    case (r_state)
      ARB_IDLE, ARB_GAP: begin
        if (w_win_valid) begin
          w_nxt_state    = ARB_OWNED;
          w_nxt_grant    = w_win_grant;
          w_nxt_owner    = w_win_idx;
          w_nxt_hold_cnt = HOLD_W'(1);
          if (w_win_idx != '0) w_nxt_rr_ptr = w_win_idx;
        end else begin
          w_nxt_state    = ARB_IDLE;
          w_nxt_grant    = '0;
          w_nxt_hold_cnt = '0;
        end
      end
      ARB_OWNED: begin
        if (!w_release) begin
          w_nxt_hold_cnt = r_hold_cnt + HOLD_W'(1);
        end else if (TURNAROUND != 0) begin
          w_nxt_state    = ARB_GAP;
          w_nxt_grant    = '0;
          w_nxt_hold_cnt = '0;
        end else if (w_win_valid) begin
          w_nxt_state    = ARB_OWNED;
          w_nxt_grant    = w_win_grant;
          w_nxt_owner    = w_win_idx;
          w_nxt_hold_cnt = HOLD_W'(1);
          if (w_win_idx != '0) w_nxt_rr_ptr = w_win_idx;
        end else begin
          w_nxt_state    = ARB_IDLE;
          w_nxt_grant    = '0;
          w_nxt_hold_cnt = '0;
        end
      end
      default: begin
        w_nxt_state    = ARB_IDLE;
        w_nxt_grant    = '0;
        w_nxt_hold_cnt = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= ARB_IDLE;
      r_grant    <= '0;
      r_owner    <= '0;
      r_rr_ptr   <= '0;
      r_hold_cnt <= '0;
      r_mask     <= '0;
    end else begin
      r_state    <= w_nxt_state;
      r_grant    <= w_nxt_grant;
      r_owner    <= w_nxt_owner;
      r_rr_ptr   <= w_nxt_rr_ptr;
      r_hold_cnt <= w_nxt_hold_cnt;
      r_mask     <= w_nxt_mask;
    end
  end

  assign grant       = r_grant;
  assign owner       = r_owner;
  assign bus_busy    = |r_grant;
  assign timeout     = w_rel_wdog;
  assign o_dbg_state = r_state;

  a_grant_onehot0: assert property (@(posedge clock) disable iff (!reset) $onehot0(r_grant));

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: scenario tasks plus randomized traffic against a
// cycle-level model of the arbitration rules, for both turnaround settings.
module tb_bus_arbiter;

  localparam int N    = 7;
  localparam int MAXH = 15;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] req   = '0;
  logic [6:0] lock  = '0;

  logic [6:0] grant_a, grant_b;
  logic [2:0] owner_a, owner_b;
  logic       busy_a, busy_b;
  logic       timeout_a, timeout_b;
  logic [1:0] state_a, state_b;

  int n_pass  = 0;
  int n_total = 0;

  // Model state: index 0 = turnaround instance, index 1 = back-to-back instance.
  bit         m_busy [2];
  int         m_owner[2];
  int         m_hold [2];
  int         m_ptr  [2];
  bit [6:0]   m_mask [2];
  bit         exp_to [2];
  bit         seen_to[2];

  always #5 clock = ~clock;

  bus_arbiter #(.NUM_REQ(N), .MAX_HOLD(MAXH), .TURNAROUND(1)) dut_a (
    .clock(clock), .reset(reset), .req(req), .lock(lock),
    .grant(grant_a), .owner(owner_a), .bus_busy(busy_a),
    .timeout(timeout_a), .o_dbg_state(state_a)
  );

  bus_arbiter #(.NUM_REQ(N), .MAX_HOLD(MAXH), .TURNAROUND(0)) dut_b (
    .clock(clock), .reset(reset), .req(req), .lock(lock),
    .grant(grant_b), .owner(owner_b), .bus_busy(busy_b),
    .timeout(timeout_b), .o_dbg_state(state_b)
  );

  task automatic model_reset();
    for (int n = 0; n < 2; n++) begin
      m_busy[n] = 1'b0; m_owner[n] = 0; m_hold[n] = 0; m_ptr[n] = 0; m_mask[n] = '0;
    end
  endtask

  function automatic logic [6:0] m_grant(int n);
    return m_busy[n] ? (7'b1 << m_owner[n]) : 7'b0;
  endfunction

  function automatic bit model_timeout(int n);
    bit pre;
    if (!m_busy[n] || !req[m_owner[n]]) return 1'b0;
    pre = req[0] && (m_owner[n] != 0) && !lock[m_owner[n]];
    return !pre && (m_hold[n] == MAXH);
  endfunction

  // Control unit first, otherwise walk upward from the last non-zero winner.
  function automatic int model_choose(int n, bit [6:0] elig);
    int i;
    if (elig[0]) return 0;
    i = m_ptr[n];
    for (int k = 0; k < N - 1; k++) begin
      i = (i >= N - 1) ? 1 : i + 1;
      if (elig[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_take(int n, int w);
    if (w >= 0) begin
      m_busy[n] = 1'b1; m_owner[n] = w; m_hold[n] = 1;
      if (w != 0) m_ptr[n] = w;
    end
  endtask

  task automatic model_step(int n);
    bit [6:0] elig;
    bit [6:0] nmask;
    bit       drop, pre, wd;
    int       own;
    elig  = req & ~m_mask[n];
    nmask = m_mask[n] & req;
    own   = m_owner[n];
    if (m_busy[n]) begin
      drop = !req[own];
      pre  = !drop && req[0] && own != 0 && !lock[own];
      wd   = !drop && !pre && m_hold[n] == MAXH;
      if (drop || pre || wd) begin
        if (wd) begin nmask[own] = 1'b1; elig[own] = 1'b0; end
        m_busy[n] = 1'b0;
        m_hold[n] = 0;
        if (n == 1) model_take(n, model_choose(n, elig));
      end else begin
        m_hold[n] = m_hold[n] + 1;
      end
    end else begin
      model_take(n, model_choose(n, elig));
    end
    m_mask[n] = nmask;
  endtask

  // One clock: sample the pre-edge timeout, advance DUT and model, settle.
  task automatic tick();
    #1;
    exp_to[0]  = model_timeout(0);
    exp_to[1]  = model_timeout(1);
    seen_to[0] = timeout_a;
    seen_to[1] = timeout_b;
    @(posedge clock);
    model_step(0);
    model_step(1);
    #1;
  endtask

  task automatic do_reset();
    req = '0; lock = '0; reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b0; req = 7'h7F; lock = '0;
    repeat (3) @(posedge clock);
    #1;
    n_total++; if (grant_a !== 7'h00) $display("FAIL reset_grant got %h exp 00", grant_a); else n_pass++;
    n_total++; if (busy_a !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy_a); else n_pass++;
    n_total++; if (owner_a !== 3'd0) $display("FAIL reset_owner got %0d exp 0", owner_a); else n_pass++;
    n_total++; if (timeout_a !== 1'b0) $display("FAIL reset_timeout got %b exp 0", timeout_a); else n_pass++;
    n_total++; if (state_a !== 2'd0) $display("FAIL reset_state got %0d exp 0", state_a); else n_pass++;
    n_total++; if (grant_b !== 7'h00) $display("FAIL reset_grant_b got %h exp 00", grant_b); else n_pass++;
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    req = 7'b0000110;
    tick();
    n_total++; if (grant_a !== 7'b0000010) $display("FAIL first_grant got %h exp 02", grant_a); else n_pass++;
    n_total++; if (owner_a !== 3'd1) $display("FAIL first_owner got %0d exp 1", owner_a); else n_pass++;
    n_total++; if (grant_a !== m_grant(0)) $display("FAIL first_grant_model got %h exp %h", grant_a, m_grant(0)); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [6:0] rr_exp [9];
    rr_exp = '{7'h02, 7'h02, 7'h00, 7'h04, 7'h04, 7'h00, 7'h08, 7'h08, 7'h00};
    do_reset();
    req = 7'b0001110;
    for (int k = 0; k < 9; k++) begin
      tick();
      n_total++;
      if (grant_a !== rr_exp[k]) $display("FAIL rr_grant[%0d] got %h exp %h", k, grant_a, rr_exp[k]);
      else n_pass++;
      if (k > 0 && rr_exp[k] != 7'h00 && rr_exp[k] == rr_exp[k-1]) req = req & ~rr_exp[k];
    end
    req = '0;
    tick();
  endtask

  task automatic test_preempt();
    logic [6:0] pre_exp [4];
    pre_exp = '{7'h20, 7'h20, 7'h00, 7'h01};
    do_reset();
    req = 7'h20;
    for (int k = 0; k < 4; k++) begin
      if (k == 2) req = 7'h21;
      tick();
      n_total++;
      if (grant_a !== pre_exp[k]) $display("FAIL preempt[%0d] got %h exp %h", k, grant_a, pre_exp[k]);
      else n_pass++;
    end
    req = '0;
    tick(); tick();
    req = 7'h20; lock = 7'h20;
    tick();
    n_total++; if (grant_a !== 7'h20) $display("FAIL lock_first got %h exp 20", grant_a); else n_pass++;
    req = 7'h21;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_total++; if (grant_a !== 7'h20) $display("FAIL lock_hold[%0d] got %h exp 20", k, grant_a); else n_pass++;
    end
    req = 7'h01;
    tick();
    n_total++; if (grant_a !== 7'h00) $display("FAIL lock_gap got %h exp 00", grant_a); else n_pass++;
    tick();
    n_total++; if (grant_a !== 7'h01) $display("FAIL lock_cu got %h exp 01", grant_a); else n_pass++;
    req = '0; lock = '0;
    tick(); tick();
  endtask

  task automatic test_watchdog();
    int cnt_g_a, cnt_g_b, cnt_to_a, cnt_to_b;
    cnt_g_a = 0; cnt_g_b = 0; cnt_to_a = 0; cnt_to_b = 0;
    do_reset();
    req = 7'h10;
    repeat (20) begin
      tick();
      if (seen_to[0]) cnt_to_a++;
      if (seen_to[1]) cnt_to_b++;
      if (grant_a[4]) cnt_g_a++;
      if (grant_b[4]) cnt_g_b++;
    end
    n_total++; if (cnt_g_a != 15) $display("FAIL wd_grant_cycles got %0d exp 15", cnt_g_a); else n_pass++;
    n_total++; if (cnt_to_a != 1) $display("FAIL wd_timeout_pulses got %0d exp 1", cnt_to_a); else n_pass++;
    n_total++; if (cnt_g_b != 15) $display("FAIL wd_grant_cycles_b got %0d exp 15", cnt_g_b); else n_pass++;
    n_total++; if (cnt_to_b != 1) $display("FAIL wd_timeout_pulses_b got %0d exp 1", cnt_to_b); else n_pass++;
    n_total++; if (grant_a !== 7'h00) $display("FAIL wd_masked got %h exp 00", grant_a); else n_pass++;
    req = '0;
    tick();
    n_total++; if (grant_a !== 7'h00) $display("FAIL wd_idle got %h exp 00", grant_a); else n_pass++;
    req = 7'h10;
    tick();
    n_total++; if (grant_a !== 7'h10) $display("FAIL wd_regrant got %h exp 10", grant_a); else n_pass++;
    req = '0;
    tick(); tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 7'h04;
    tick(); tick();
    n_total++; if (grant_a !== 7'h04) $display("FAIL ar_pre got %h exp 04", grant_a); else n_pass++;
    #2;
    reset = 1'b0;
    #1;
    n_total++; if (grant_a !== 7'h00) $display("FAIL ar_grant got %h exp 00", grant_a); else n_pass++;
    n_total++; if (busy_a !== 1'b0) $display("FAIL ar_busy got %b exp 0", busy_a); else n_pass++;
    n_total++; if (timeout_a !== 1'b0) $display("FAIL ar_timeout got %b exp 0", timeout_a); else n_pass++;
    n_total++; if (grant_b !== 7'h00) $display("FAIL ar_grant_b got %h exp 00", grant_b); else n_pass++;
    @(posedge clock); #1;
    n_total++; if (grant_a !== 7'h00) $display("FAIL ar_held got %h exp 00", grant_a); else n_pass++;
    @(negedge clock);
    req = '0;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_back_to_back();
    do_reset();
    req = 7'b0000110;
    tick();
    n_total++; if (grant_b !== 7'h02) $display("FAIL b2b_first got %h exp 02", grant_b); else n_pass++;
    req = 7'b0000100;
    tick();
    n_total++; if (grant_b !== 7'h04) $display("FAIL b2b_next got %h exp 04", grant_b); else n_pass++;
    n_total++; if (grant_a !== 7'h00) $display("FAIL ta_gap got %h exp 00", grant_a); else n_pass++;
    tick();
    n_total++; if (grant_a !== 7'h04) $display("FAIL ta_after_gap got %h exp 04", grant_a); else n_pass++;
    n_total++; if (grant_b !== 7'h04) $display("FAIL b2b_hold got %h exp 04", grant_b); else n_pass++;
    req = '0;
    tick(); tick();
  endtask

  task automatic test_random();
    int flip_den;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      flip_den = (c < 300) ? 4 : 24;
      for (int b = 1; b < N; b++)
        if ($urandom_range(0, flip_den - 1) == 0) req[b] = ~req[b];
      if ($urandom_range(0, 2 * flip_den - 1) == 0) req[0] = ~req[0];
      if ($urandom_range(0, 7) == 0) lock = 7'($urandom_range(0, 127));
      tick();
      n_total++; if (seen_to[0] !== exp_to[0]) $display("FAIL rnd_timeout_a c=%0d got %b exp %b", c, seen_to[0], exp_to[0]); else n_pass++;
      n_total++; if (grant_a !== m_grant(0)) $display("FAIL rnd_grant_a c=%0d got %h exp %h", c, grant_a, m_grant(0)); else n_pass++;
      n_total++; if (owner_a !== 3'(m_owner[0])) $display("FAIL rnd_owner_a c=%0d got %0d exp %0d", c, owner_a, m_owner[0]); else n_pass++;
      n_total++; if (busy_a !== m_busy[0]) $display("FAIL rnd_busy_a c=%0d got %b exp %b", c, busy_a, m_busy[0]); else n_pass++;
      n_total++; if (!$onehot0(grant_a)) $display("FAIL rnd_onehot_a c=%0d got %h exp onehot0", c, grant_a); else n_pass++;
      n_total++; if (seen_to[1] !== exp_to[1]) $display("FAIL rnd_timeout_b c=%0d got %b exp %b", c, seen_to[1], exp_to[1]); else n_pass++;
      n_total++; if (grant_b !== m_grant(1)) $display("FAIL rnd_grant_b c=%0d got %h exp %h", c, grant_b, m_grant(1)); else n_pass++;
      n_total++; if (owner_b !== 3'(m_owner[1])) $display("FAIL rnd_owner_b c=%0d got %0d exp %0d", c, owner_b, m_owner[1]); else n_pass++;
      n_total++; if (busy_b !== m_busy[1]) $display("FAIL rnd_busy_b c=%0d got %b exp %b", c, busy_b, m_busy[1]); else n_pass++;
      n_total++; if (!$onehot0(grant_b)) $display("FAIL rnd_onehot_b c=%0d got %h exp onehot0", c, grant_b); else n_pass++;
    end
    req = '0; lock = '0;
    tick(); tick();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_round_robin();
    test_preempt();
    test_watchdog();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
